// File: rtl/sys_ctrl.sv
// Command sequencer: decodes framed RX bytes into register file writes/reads and
// ALU operations, and returns read data or ALU results as bytes to the TX FIFO.
module sys_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int FUN_WIDTH     = 4,
    parameter int ALU_OUT_WIDTH = 16,
    parameter int WAIT_TIMEOUT  = 15
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]    RdData,
    input  logic                     RdData_Valid,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     ALU_OUT_VALID,
    input  logic                     FIFO_FULL,
    output logic                     WrEn,
    output logic                     RdEn,
    output logic [ADDR_WIDTH-1:0]    Address,
    output logic [DATA_WIDTH-1:0]    WrData,
    output logic                     ALU_EN,
    output logic [FUN_WIDTH-1:0]     ALU_FUN,
    output logic                     CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD
);

    localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_WR_ADDR  = 4'd1;
    localparam logic [3:0] S_WR_DATA  = 4'd2;
    localparam logic [3:0] S_RD_ADDR  = 4'd3;
    localparam logic [3:0] S_RD_WAIT  = 4'd4;
    localparam logic [3:0] S_OPA      = 4'd5;
    localparam logic [3:0] S_OPB      = 4'd6;
    localparam logic [3:0] S_FUN      = 4'd7;
    localparam logic [3:0] S_ALU_WAIT = 4'd8;
    localparam logic [3:0] S_TX_SEND0 = 4'd9;
    localparam logic [3:0] S_TX_SEND1 = 4'd10;

    localparam logic [DATA_WIDTH-1:0] OP_WR      = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OP_RD      = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] OP_ALU_OP  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] OP_ALU_NOP = DATA_WIDTH'(8'hDD);

    logic [3:0]               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [ALU_OUT_WIDTH-1:0] buf_q, buf_d;
    logic                     two_q, two_d;
    logic                     wr_en_q, wr_en_d;
    logic                     rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0]    address_q, address_d;
    logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
    logic                     alu_en_q, alu_en_d;
    logic [FUN_WIDTH-1:0]     alu_fun_q, alu_fun_d;
    logic                     clk_gate_en_q, clk_gate_en_d;
    logic [DATA_WIDTH-1:0]    tx_data_q, tx_data_d;
    logic                     tx_vld_q, tx_vld_d;
    logic                     wait_done_s;

    // Last waiting cycle: a valid here still wins over the abort.
    assign wait_done_s = (cnt_q == CNT_W'(WAIT_TIMEOUT - 1));

    // Next-state and next-output decode for the command sequencer.
    always_comb begin
        state_d       = state_q;
        cnt_d         = {CNT_W{1'b0}};
        buf_d         = buf_q;
        two_d         = two_q;
        wr_en_d       = 1'b0;
        rd_en_d       = 1'b0;
        address_d     = address_q;
        wr_data_d     = wr_data_q;
        alu_en_d      = 1'b0;
        alu_fun_d     = alu_fun_q;
        clk_gate_en_d = 1'b0;
        tx_data_d     = tx_data_q;
        tx_vld_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        OP_WR:      state_d = S_WR_ADDR;
                        OP_RD:      state_d = S_RD_ADDR;
                        OP_ALU_OP:  state_d = S_OPA;
                        OP_ALU_NOP: state_d = S_FUN;
                        default:    state_d = S_IDLE;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR_ADDR: begin
                if (RX_D_VLD) begin
                    address_d = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d   = S_WR_DATA;
                end else begin
                    state_d = S_WR_ADDR;
                end
            end
            S_WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = RX_P_DATA;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_WR_DATA;
                end
            end
            S_RD_ADDR: begin
                if (RX_D_VLD) begin
                    address_d = RX_P_DATA[ADDR_WIDTH-1:0];
                    rd_en_d   = 1'b1;
                    state_d   = S_RD_WAIT;
                end else begin
                    state_d = S_RD_ADDR;
                end
            end
            S_RD_WAIT: begin
                if (RdData_Valid) begin
                    buf_d   = {{(ALU_OUT_WIDTH-DATA_WIDTH){1'b0}}, RdData};
                    two_d   = 1'b0;
                    state_d = S_TX_SEND0;
                end else if (wait_done_s) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_OPA, S_OPB: begin
                if (RX_D_VLD) begin
                    wr_en_d   = 1'b1;
                    address_d = (state_q == S_OPA) ? ADDR_WIDTH'(0) : ADDR_WIDTH'(1);
                    wr_data_d = RX_P_DATA;
                    state_d   = (state_q == S_OPA) ? S_OPB : S_FUN;
                end else begin
                    state_d = state_q;
                end
            end
            S_FUN: begin
                if (RX_D_VLD) begin
                    alu_fun_d     = RX_P_DATA[FUN_WIDTH-1:0];
                    alu_en_d      = 1'b1;
                    clk_gate_en_d = 1'b1;
                    state_d       = S_ALU_WAIT;
                end else begin
                    state_d = S_FUN;
                end
            end
            S_ALU_WAIT: begin
                if (ALU_OUT_VALID) begin
                    buf_d   = ALU_OUT;
                    two_d   = 1'b1;
                    state_d = S_TX_SEND0;
                end else if (wait_done_s) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d         = cnt_q + CNT_W'(1);
                    clk_gate_en_d = 1'b1;
                end
            end
            S_TX_SEND0: begin
                if (!FIFO_FULL) begin
                    tx_vld_d  = 1'b1;
                    tx_data_d = buf_q[DATA_WIDTH-1:0];
                    state_d   = two_q ? S_TX_SEND1 : S_IDLE;
                end else begin
                    state_d = S_TX_SEND0;
                end
            end
            S_TX_SEND1: begin
                if (!FIFO_FULL) begin
                    tx_vld_d  = 1'b1;
                    tx_data_d = buf_q[ALU_OUT_WIDTH-1:DATA_WIDTH];
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_TX_SEND1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= S_IDLE;
            cnt_q         <= {CNT_W{1'b0}};
            buf_q         <= {ALU_OUT_WIDTH{1'b0}};
            two_q         <= 1'b0;
            wr_en_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            address_q     <= {ADDR_WIDTH{1'b0}};
            wr_data_q     <= {DATA_WIDTH{1'b0}};
            alu_en_q      <= 1'b0;
            alu_fun_q     <= {FUN_WIDTH{1'b0}};
            clk_gate_en_q <= 1'b0;
            tx_data_q     <= {DATA_WIDTH{1'b0}};
            tx_vld_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            buf_q         <= buf_d;
            two_q         <= two_d;
            wr_en_q       <= wr_en_d;
            rd_en_q       <= rd_en_d;
            address_q     <= address_d;
            wr_data_q     <= wr_data_d;
            alu_en_q      <= alu_en_d;
            alu_fun_q     <= alu_fun_d;
            clk_gate_en_q <= clk_gate_en_d;
            tx_data_q     <= tx_data_d;
            tx_vld_q      <= tx_vld_d;
        end
    end

    assign WrEn        = wr_en_q;
    assign RdEn        = rd_en_q;
    assign Address     = address_q;
    assign WrData      = wr_data_q;
    assign ALU_EN      = alu_en_q;
    assign ALU_FUN     = alu_fun_q;
    assign CLK_GATE_EN = clk_gate_en_q;
    assign TX_P_DATA   = tx_data_q;
    assign TX_D_VLD    = tx_vld_q;

endmodule

// File: doc/sys_ctrl.md
Name: sys_ctrl

Overview:
Command sequencer between the synchronized UART RX byte stream and the register file / ALU. It decodes framed commands into register file writes and reads and ALU operations, then returns read data or ALU results as bytes to the TX FIFO. It runs entirely in the reference clock domain, and it owns the ALU clock-gate enable.

Parameters:
DATA_WIDTH, 8, width of RX/TX bytes and register file data
ADDR_WIDTH, 4, register file address width; the low ADDR_WIDTH bits of the address byte are used
FUN_WIDTH, 4, ALU function width; the low FUN_WIDTH bits of the function byte are used
ALU_OUT_WIDTH, 16, ALU result width; must equal 2*DATA_WIDTH
WAIT_TIMEOUT, 15, cycles to wait for RdData_Valid or ALU_OUT_VALID before aborting

Ports:
CLK  in  1  reference clock
RST  in  1  asynchronous active-low reset
RX_P_DATA  in  DATA_WIDTH  received byte
RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
RdData  in  DATA_WIDTH  register file read data
RdData_Valid  in  1  register file read data valid
ALU_OUT  in  ALU_OUT_WIDTH  ALU result
ALU_OUT_VALID  in  1  ALU result valid
FIFO_FULL  in  1  TX FIFO full
WrEn  out  1  register file write enable
RdEn  out  1  register file read enable
Address  out  ADDR_WIDTH  register file address
WrData  out  DATA_WIDTH  register file write data
ALU_EN  out  1  ALU start strobe
ALU_FUN  out  FUN_WIDTH  ALU function select
CLK_GATE_EN  out  1  ALU clock gate enable
TX_P_DATA  out  DATA_WIDTH  byte pushed to TX FIFO
TX_D_VLD  out  1  TX FIFO push strobe

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0.
- All outputs are registered. WrEn, RdEn, ALU_EN and TX_D_VLD are single-cycle pulses, asserted in the cycle after the triggering event.
- Command opcodes, first byte in IDLE:
  - 0xAA: write; frame is addr, data.
  - 0xBB: read; frame is addr.
  - 0xCC: ALU with operands; frame is A, B, fun.
  - 0xDD: ALU without operands; frame is fun.
- Any other byte in IDLE is dropped, and the state stays IDLE.
- Write path, IDLE -> WR_ADDR -> WR_DATA:
  - The addr byte is latched into Address.
  - On the data byte: WrEn=1 and WrData=byte for one cycle, then IDLE.
- Read path, IDLE -> RD_ADDR -> RD_WAIT:
  - On the addr byte: Address=addr and RdEn=1 for one cycle.
  - In RD_WAIT, RdData_Valid captures RdData -> TX_SEND0 (one byte to send).
- ALU path with operands, IDLE -> OPA -> OPB -> FUN:
  - A byte: WrEn pulse with Address=0, WrData=A.
  - B byte: WrEn pulse with Address=1, WrData=B.
  - FUN continues as below.
- ALU path without operands: IDLE -> FUN directly.
- FUN byte:
  - ALU_FUN is latched and ALU_EN pulses one cycle -> ALU_WAIT.
  - CLK_GATE_EN=1 from the ALU_EN cycle through the cycle ALU_OUT_VALID is seen; otherwise 0.
  - In ALU_WAIT, ALU_OUT_VALID captures ALU_OUT -> TX_SEND0 (two bytes to send).
- TX_SEND0:
  - When FIFO_FULL=0: TX_D_VLD=1 and TX_P_DATA = the read byte or ALU_OUT[7:0].
  - After a one-byte send -> IDLE; after a two-byte send -> TX_SEND1.
- TX_SEND1: when FIFO_FULL=0, push ALU_OUT[15:8] -> IDLE.
- FIFO_FULL=1 in either send state holds the state with no push. Pushes never occur while FIFO_FULL=1.
- Timeout:
  - The counter increments every cycle in RD_WAIT/ALU_WAIT and clears on state exit.
  - At WAIT_TIMEOUT with no valid: return IDLE, no TX push, CLK_GATE_EN=0.
- Valid arriving in the same cycle the count reaches WAIT_TIMEOUT: valid wins.
- RX_D_VLD in RD_WAIT, ALU_WAIT or the send states: byte dropped.
- WrEn and RdEn are never asserted together.
- Address holds its last value between commands.
- RST low mid-frame or mid-wait: immediate return to the reset state. A partial frame is discarded and nothing is pushed.

Test Plan:
- Write: RX AA,05,3C -> single WrEn pulse with Address=5, WrData=0x3C; no TX push.
- Read: RX BB,05; RdData=0x3C with RdData_Valid one cycle after RdEn -> RdEn pulse with Address=5; TX_P_DATA=0x3C, one TX_D_VLD.
- ALU with operands: RX CC,0A,14,00 -> writes to addr 0=0x0A and addr 1=0x14; ALU_EN with ALU_FUN=0; CLK_GATE_EN high. ALU_OUT=0x001E valid -> pushes 0x1E then 0x00; CLK_GATE_EN low.
- Backpressure: ALU_OUT=0xABCD with FIFO_FULL=1 for 4 cycles -> no push while full, then 0xCD, then 0xAB.
- Timeout and illegal input: RX BB,02 with no RdData_Valid for 15 cycles -> IDLE, no push. RX 0x55 in IDLE -> ignored; a following AA,01,FF executes normally.
- Reset mid-frame: RX AA,07 then RST low -> all outputs 0. After release, RX 0x12 is ignored.
